ap3_sync_fifo: RTL and testbench

- Parametrised single-clock synchronous FIFO simulation model for the AP3 fabric; the next generation of the fixed 32-bit RAM/FIFO cell.
- Generalised data width and depth, programmable almost-empty/almost-full thresholds and synchronous flush.
- Adds count output, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode.
- Instantiated by the QuickLogic techmap flow wherever an inferred FIFO does not fit the hard RAM macro.

---
 rtl/ap3_fifo_pkg.sv | 43 ++++
 rtl/ap3_fifo_mem.sv | 34 +++
 rtl/ap3_sync_fifo.sv | 115 +++++++++++
 tb/tb_ap3_sync_fifo.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ap3_fifo_pkg.sv
// ap3_fifo_pkg
// Shared definitions for the AP3 synchronous FIFO: flag bit positions in
// FFLAGS, the packed flag record, depth helper, parameter legality check
// and the flag computation used for both reset and run-time updates.
package ap3_fifo_pkg;

    localparam int FF_EMPTY = 0;
    localparam int FF_AE    = 1;
    localparam int FF_AF    = 2;
    localparam int FF_FULL  = 3;

    // Bit order matches FFLAGS: {FULL, ALMOST_FULL, ALMOST_EMPTY, EMPTY}
    typedef struct packed {
        logic full;
        logic af;
        logic ae;
        logic empty;
    } fifo_flags_t;

    function automatic int fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

    function automatic bit params_ok(input int dw, input int dl2, input int ae,
                                     input int af, input int fwft);
        int depth;
        depth = fifo_depth(dl2);
        return (dw >= 1) && (dw <= 64) && (dl2 >= 2) && (dl2 <= 12) &&
               (ae >= 0) && (ae < depth) && (af >= 0) && (af < depth) &&
               ((fwft == 0) || (fwft == 1));
    endfunction

    function automatic fifo_flags_t calc_flags(input int cnt, input int depth,
                                               input int ae, input int af);
        fifo_flags_t f;
        f.empty = (cnt == 0);
        f.full  = (cnt == depth);
        f.ae    = (cnt <= ae);
        f.af    = (cnt >= depth - af);
        return f;
    endfunction

endpackage

// File: rtl/ap3_fifo_mem.sv
// ap3_fifo_mem
// Simple dual-port storage array: one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   CLK    - write clock
//   WE     - write enable
//   WADDR  - write address
//   WDATA  - write data
//   RADDR  - read address
//   RDATA  - read data (combinational from RADDR)
module ap3_fifo_mem
    import ap3_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  CLK,
    input  logic                  WE,
    input  logic [DEPTH_LOG2-1:0] WADDR,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [DEPTH_LOG2-1:0] RADDR,
    output logic [DATA_WIDTH-1:0] RDATA
);

    localparam int DEPTH = fifo_depth(DEPTH_LOG2);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (WE) mem[WADDR] <= WDATA;
    end

    assign RDATA = mem[RADDR];

endmodule

// File: rtl/ap3_sync_fifo.sv
// ap3_sync_fifo
// Single-clock synchronous FIFO with programmable almost-empty/almost-full
// thresholds, synchronous flush, occupancy count, sticky error flags and an
// optional first-word-fall-through read mode.
//   CLK    - clock, all state updates on rising edge
//   RST    - synchronous reset, active-high
//   WEN    - write request
//   WDATA  - write data
//   REN    - read request (pop)
//   FFLUSH - synchronous flush, empties the FIFO
//   RDATA  - read data (registered, or head word when FWFT=1)
//   FFLAGS - {FULL, ALMOST_FULL, ALMOST_EMPTY, EMPTY}, registered
//   COUNT  - occupancy 0..DEPTH
//   OVF    - sticky: write attempted while FULL
//   UDF    - sticky: read attempted while EMPTY
module ap3_sync_fifo
    import ap3_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 9,
    parameter int AE_THRESH  = 4,
    parameter int AF_THRESH  = 4,
    parameter int FWFT       = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WEN,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  REN,
    input  logic                  FFLUSH,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [3:0]            FFLAGS,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  OVF,
    output logic                  UDF
);

    localparam int DEPTH = fifo_depth(DEPTH_LOG2);
    localparam fifo_flags_t FLAGS_RST = calc_flags(0, DEPTH, AE_THRESH, AF_THRESH);

    if (!params_ok(DATA_WIDTH, DEPTH_LOG2, AE_THRESH, AF_THRESH, FWFT)) begin : g_param_err
        $error("ap3_sync_fifo: illegal parameters DATA_WIDTH=%0d DEPTH_LOG2=%0d AE=%0d AF=%0d FWFT=%0d",
               DATA_WIDTH, DEPTH_LOG2, AE_THRESH, AF_THRESH, FWFT);
    end

    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_nxt;
    fifo_flags_t           flags_q, flags_nxt;
    logic                  ovf_q, udf_q;
    logic                  wr_ok, rd_ok, mem_we;
    logic [DATA_WIDTH-1:0] mem_rd;

    // Acceptance uses the registered (pre-edge) flags; a rejected request
    // only raises its sticky error.
    assign wr_ok  = WEN && !flags_q.full;
    assign rd_ok  = REN && !flags_q.empty;
    assign mem_we = wr_ok && !RST && !FFLUSH;

    always_comb begin
        count_nxt = count_q;
        if (wr_ok && !rd_ok)      count_nxt = count_q + 1'b1;
        else if (rd_ok && !wr_ok) count_nxt = count_q - 1'b1;
        flags_nxt = calc_flags(int'(count_nxt), DEPTH, AE_THRESH, AF_THRESH);
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (RST || FFLUSH) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            flags_q <= FLAGS_RST;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + 1'b1;
            if (rd_ok) rptr_q <= rptr_q + 1'b1;
            count_q <= count_nxt;
            flags_q <= flags_nxt;
            if (WEN && flags_q.full)  ovf_q <= 1'b1;
            if (REN && flags_q.empty) udf_q <= 1'b1;
        end
    end

    ap3_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .CLK   (CLK),
        .WE    (mem_we),
        .WADDR (wptr_q),
        .WDATA (WDATA),
        .RADDR (rptr_q),
        .RDATA (mem_rd)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word shown directly; zero while empty so reset reads as 0.
        assign RDATA = flags_q.empty ? '0 : mem_rd;
    end else begin : g_reg_rd
        logic [DATA_WIDTH-1:0] rdata_q;
        // Flush deliberately leaves the last read word visible.
        always_ff @(posedge CLK) begin
            if (RST)                  rdata_q <= '0;
            else if (!FFLUSH && rd_ok) rdata_q <= mem_rd;
        end
        assign RDATA = rdata_q;
    end

    assign FFLAGS = flags_q;
    assign COUNT  = count_q;
    assign OVF    = ovf_q;
    assign UDF    = udf_q;

endmodule

// File: tb/tb_ap3_sync_fifo.sv
// tb_ap3_sync_fifo
// Directed bench: table-driven fill/drain on a 16-deep registered-read FIFO,
// followed by hand-written sequences for concurrent read/write with wrap,
// full-with-read, flush, reset mid-operation and an FWFT instance.
module tb_ap3_sync_fifo;

    logic        CLK = 1'b0;
    logic        rst, wen, ren, flush;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  fflags;
    logic [4:0]  count;
    logic        ovf, udf;

    logic        rst_f, wen_f, ren_f, flush_f;
    logic [31:0] wdata_f;
    logic [31:0] rdata_f;
    logic [3:0]  fflags_f;
    logic [4:0]  count_f;
    logic        ovf_f, udf_f;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    ap3_sync_fifo #(.DATA_WIDTH(32), .DEPTH_LOG2(4), .AE_THRESH(4), .AF_THRESH(4), .FWFT(0)) dut (
        .CLK(CLK), .RST(rst), .WEN(wen), .WDATA(wdata), .REN(ren), .FFLUSH(flush),
        .RDATA(rdata), .FFLAGS(fflags), .COUNT(count), .OVF(ovf), .UDF(udf)
    );

    ap3_sync_fifo #(.DATA_WIDTH(32), .DEPTH_LOG2(4), .AE_THRESH(4), .AF_THRESH(4), .FWFT(1)) dut_f (
        .CLK(CLK), .RST(rst_f), .WEN(wen_f), .WDATA(wdata_f), .REN(ren_f), .FFLUSH(flush_f),
        .RDATA(rdata_f), .FFLAGS(fflags_f), .COUNT(count_f), .OVF(ovf_f), .UDF(udf_f)
    );

    typedef struct {
        logic        rst, wen, ren, flush;
        logic [31:0] wdata;
        logic [4:0]  e_cnt;
        logic [3:0]  e_flags;
        logic        e_ovf, e_udf;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vt[35];

    // Expected {FULL, AF, AE, EMPTY} for depth 16, AE=AF=4
    function automatic logic [3:0] ef(input int c);
        return {(c == 16), (c >= 12), (c <= 4), (c == 0)};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk0(input string nm, input int c, input logic [3:0] fl,
                        input logic o, input logic u, input logic [31:0] rd);
        check({nm, ".count"}, 64'(count), 64'(c));
        check({nm, ".flags"}, 64'(fflags), 64'(fl));
        check({nm, ".ovf"}, 64'(ovf), 64'(o));
        check({nm, ".udf"}, 64'(udf), 64'(u));
        check({nm, ".rdata"}, 64'(rdata), 64'(rd));
    endtask

    task automatic drv(input logic r, input logic w, input logic [31:0] d,
                       input logic rd, input logic f);
        rst = r; wen = w; wdata = d; ren = rd; flush = f;
        @(posedge CLK); #1;
    endtask

    task automatic drv_f(input logic r, input logic w, input logic [31:0] d, input logic rd);
        rst_f = r; wen_f = w; wdata_f = d; ren_f = rd; flush_f = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; wen = 1'b0; ren = 1'b0; flush = 1'b0; wdata = '0;
        rst_f = 1'b1; wen_f = 1'b0; ren_f = 1'b0; flush_f = 1'b0; wdata_f = '0;

        // Fill/drain table
        vt[0] = '{rst:1, wen:1, ren:1, flush:0, wdata:32'hFFFF, e_cnt:0, e_flags:4'b0011,
                  e_ovf:0, e_udf:0, e_rdata:0};
        for (int i = 1; i <= 16; i++)
            vt[i] = '{rst:0, wen:1, ren:0, flush:0, wdata:32'(i), e_cnt:5'(i), e_flags:ef(i),
                      e_ovf:0, e_udf:0, e_rdata:0};
        vt[17] = '{rst:0, wen:1, ren:0, flush:0, wdata:32'h11, e_cnt:16, e_flags:4'b1100,
                   e_ovf:1, e_udf:0, e_rdata:0};
        for (int k = 1; k <= 16; k++)
            vt[17+k] = '{rst:0, wen:0, ren:1, flush:0, wdata:0, e_cnt:5'(16-k), e_flags:ef(16-k),
                         e_ovf:1, e_udf:0, e_rdata:32'(k)};
        vt[34] = '{rst:0, wen:0, ren:1, flush:0, wdata:0, e_cnt:0, e_flags:4'b0011,
                   e_ovf:1, e_udf:1, e_rdata:32'h10};

        for (int i = 0; i < 35; i++) begin
            drv(vt[i].rst, vt[i].wen, vt[i].wdata, vt[i].ren, vt[i].flush);
            chk0($sformatf("vec%0d", i), int'(vt[i].e_cnt), vt[i].e_flags,
                 vt[i].e_ovf, vt[i].e_udf, vt[i].e_rdata);
            if (i == 0) begin
                check("fwft_rst.count", 64'(count_f), 64'(0));
                check("fwft_rst.flags", 64'(fflags_f), 64'(4'b0011));
                rst_f = 1'b0;
            end
        end

        // Concurrent read/write across pointer wrap
        drv(0, 0, 0, 0, 1);
        chk0("flush0", 0, 4'b0011, 0, 0, 32'h10);
        for (int i = 0; i < 8; i++) drv(0, 1, 32'h100 + 32'(i), 0, 0);
        check("pre_rw.count", 64'(count), 64'(8));
        for (int j = 0; j < 20; j++) begin
            drv(0, 1, 32'h108 + 32'(j), 1, 0);
            check($sformatf("rw%0d.rdata", j), 64'(rdata), 64'(32'h100 + 32'(j)));
            check($sformatf("rw%0d.count", j), 64'(count), 64'(8));
        end
        for (int i = 0; i < 8; i++) drv(0, 1, 32'h11C + 32'(i), 0, 0);
        chk0("full", 16, 4'b1100, 0, 0, 32'h113);
        // At FULL: read taken, write dropped
        drv(0, 1, 32'hDEAD, 1, 0);
        chk0("full_rw", 15, 4'b0100, 1, 0, 32'h114);
        drv(0, 0, 0, 1, 0);
        chk0("after_full_rw", 14, 4'b0100, 1, 0, 32'h115);

        // Flush mid-operation with OVF set, COUNT=10
        for (int i = 0; i < 4; i++) drv(0, 0, 0, 1, 0);
        chk0("pre_flush", 10, 4'b0000, 1, 0, 32'h119);
        drv(0, 1, 32'hBAD, 0, 1);
        chk0("flush_wen", 0, 4'b0011, 0, 0, 32'h119);
        drv(0, 1, 32'h2AA, 0, 0);
        chk0("post_flush_wr", 1, 4'b0010, 0, 0, 32'h119);
        drv(0, 0, 0, 1, 0);
        chk0("post_flush_rd", 0, 4'b0011, 0, 0, 32'h2AA);

        // Reset mid-operation: UDF set, COUNT=7, WEN/REN active
        drv(0, 0, 0, 1, 0);
        chk0("udf_set", 0, 4'b0011, 0, 1, 32'h2AA);
        for (int i = 0; i < 8; i++) drv(0, 1, 32'h300 + 32'(i), 0, 0);
        drv(0, 0, 0, 1, 0);
        chk0("pre_rst", 7, 4'b0000, 0, 1, 32'h300);
        drv(1, 1, 32'h3FF, 1, 0);
        chk0("rst_mid", 0, 4'b0011, 0, 0, 32'h0);
        drv(0, 1, 32'h77, 0, 0);
        chk0("post_rst_wr", 1, 4'b0010, 0, 0, 32'h0);
        drv(0, 0, 0, 1, 0);
        chk0("post_rst_rd", 0, 4'b0011, 0, 0, 32'h77);
        drv(0, 0, 0, 0, 0);

        // FWFT instance
        drv_f(0, 1, 32'hA5, 0);
        check("fwft_wr.empty", 64'(fflags_f[0]), 64'(0));
        check("fwft_wr.rdata", 64'(rdata_f), 64'(32'hA5));
        check("fwft_wr.count", 64'(count_f), 64'(1));
        drv_f(0, 0, 0, 0);
        check("fwft_hold.rdata", 64'(rdata_f), 64'(32'hA5));
        drv_f(0, 0, 0, 1);
        check("fwft_pop.flags", 64'(fflags_f), 64'(4'b0011));
        check("fwft_pop.count", 64'(count_f), 64'(0));
        drv_f(0, 1, 32'h11, 0);
        drv_f(0, 1, 32'h22, 0);
        check("fwft_two.rdata", 64'(rdata_f), 64'(32'h11));
        check("fwft_two.count", 64'(count_f), 64'(2));
        drv_f(0, 0, 0, 1);
        check("fwft_next.rdata", 64'(rdata_f), 64'(32'h22));
        check("fwft_next.count", 64'(count_f), 64'(1));
        check("fwft.ovf_udf", 64'({ovf_f, udf_f}), 64'(0));
        drv_f(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
